// File: rtl/lsu_bus_master_pkg.sv
// Shared definitions for the load/store bus master: data-memory access types,
// FSM state encoding and the access-fault rule.
package lsu_bus_master_pkg;

  typedef enum logic [2:0] {
    dm_word              = 3'b000,
    dm_halfword          = 3'b001,
    dm_halfword_unsigned = 3'b010,
    dm_byte              = 3'b011,
    dm_byte_unsigned     = 3'b100
  } dm_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  localparam int unsigned CNT_W = 16;

  // Unknown type codes count as faults so they never reach the bus.
  function automatic logic access_fault(input logic [2:0] dm_type, input logic [1:0] lane);
    logic fault;
    case (dm_type)
      dm_word:                           fault = (lane != 2'b00);
      dm_halfword, dm_halfword_unsigned: fault = lane[0];
      dm_byte, dm_byte_unsigned:         fault = 1'b0;
      default:                           fault = 1'b1;
    endcase
    return fault;
  endfunction

endpackage

// File: rtl/lsu_bus_master_lane_align.sv
// Combinational lane steering: byte enables and replicated store data on the way
// out, load extraction with sign/zero extension on the way back.
module lsu_lane_align
  import lsu_bus_master_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Select the addressed lane(s) and build all three outputs per access type.
  always_comb begin
    rd_byte   = mem_rdata[{lane, 3'b000} +: 8];
    rd_half   = mem_rdata[{lane[1], 4'b0000} +: 16];
    be        = 4'b0000;
    wdata_rep = 32'h0000_0000;
    rdata     = 32'h0000_0000;
    case (dm_type)
      dm_word: begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata     = mem_rdata;
      end
      dm_halfword: begin
        be        = 4'b0011 << lane;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {{16{rd_half[15]}}, rd_half};
      end
      dm_halfword_unsigned: begin
        be        = 4'b0011 << lane;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {16'h0000, rd_half};
      end
      dm_byte: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {{24{rd_byte[7]}}, rd_byte};
      end
      dm_byte_unsigned: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {24'h00_0000, rd_byte};
      end
      default: begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        rdata     = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store initiator: accepts one core transaction, runs a held bus request
// until ack or timeout, and returns a single-cycle response.
module lsu_bus_master
  import lsu_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misalign,
  output logic        resp_timeout,
  output logic        mem_req,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e       state, state_next;
  logic [CNT_W-1:0] count, count_next;
  logic             lat_we, lat_we_next;
  logic [2:0]       lat_type, lat_type_next;
  logic [1:0]       lat_lane, lat_lane_next;
  logic             req_ready_next, resp_valid_next, resp_misalign_next, resp_timeout_next;
  logic [31:0]      resp_rdata_next, mem_wdata_next;
  logic             mem_req_next, mem_we_next;
  logic [29:0]      mem_addr_next;
  logic [3:0]       mem_be_next;
  logic [2:0]       align_type;
  logic [1:0]       align_lane;
  logic [3:0]       al_be;
  logic [31:0]      al_wdata, al_rdata;

  // In IDLE the aligner sees the incoming request; afterwards the latched one.
  assign align_type = (state == IDLE) ? req_type       : lat_type;
  assign align_lane = (state == IDLE) ? req_addr[1:0]  : lat_lane;

  lsu_lane_align u_align (
    .dm_type   (align_type),
    .lane      (align_lane),
    .wdata     (req_wdata),
    .mem_rdata (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata     (al_rdata)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next         = state;
    count_next         = count;
    lat_we_next        = lat_we;
    lat_type_next      = lat_type;
    lat_lane_next      = lat_lane;
    req_ready_next     = 1'b0;
    resp_valid_next    = 1'b0;
    resp_rdata_next    = 32'h0000_0000;
    resp_misalign_next = 1'b0;
    resp_timeout_next  = 1'b0;
    mem_req_next       = mem_req;
    mem_we_next        = mem_we;
    mem_addr_next      = mem_addr;
    mem_be_next        = mem_be;
    mem_wdata_next     = mem_wdata;
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          lat_we_next   = req_we;
          lat_type_next = req_type;
          lat_lane_next = req_addr[1:0];
          if (access_fault(req_type, req_addr[1:0])) begin
            state_next         = RESP;
            resp_valid_next    = 1'b1;
            resp_misalign_next = 1'b1;
          end else begin
            state_next     = BUS;
            count_next     = {CNT_W{1'b0}};
            mem_req_next   = 1'b1;
            mem_we_next    = req_we;
            mem_addr_next  = req_addr[31:2];
            mem_be_next    = al_be;
            mem_wdata_next = al_wdata;
          end
        end else begin
          req_ready_next = 1'b1;
        end
      end
      BUS: begin
        // Ack is checked first so it wins over the final timeout cycle.
        if (mem_ack) begin
          state_next      = RESP;
          mem_req_next    = 1'b0;
          mem_we_next     = 1'b0;
          resp_valid_next = 1'b1;
          resp_rdata_next = lat_we ? 32'h0000_0000 : al_rdata;
        end else if (count == CNT_LAST) begin
          state_next        = RESP;
          mem_req_next      = 1'b0;
          mem_we_next       = 1'b0;
          resp_valid_next   = 1'b1;
          resp_timeout_next = 1'b1;
        end else begin
          count_next = count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        state_next     = IDLE;
        count_next     = {CNT_W{1'b0}};
        req_ready_next = 1'b1;
      end
      default: begin
        state_next     = IDLE;
        count_next     = {CNT_W{1'b0}};
        req_ready_next = 1'b1;
        mem_req_next   = 1'b0;
        mem_we_next    = 1'b0;
      end
    endcase
  end

  // State, latched request and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      count         <= {CNT_W{1'b0}};
      lat_we        <= 1'b0;
      lat_type      <= 3'b000;
      lat_lane      <= 2'b00;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'h0000_0000;
      resp_misalign <= 1'b0;
      resp_timeout  <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 30'h0000_0000;
      mem_be        <= 4'b0000;
      mem_wdata     <= 32'h0000_0000;
    end else begin
      state         <= state_next;
      count         <= count_next;
      lat_we        <= lat_we_next;
      lat_type      <= lat_type_next;
      lat_lane      <= lat_lane_next;
      req_ready     <= req_ready_next;
      resp_valid    <= resp_valid_next;
      resp_rdata    <= resp_rdata_next;
      resp_misalign <= resp_misalign_next;
      resp_timeout  <= resp_timeout_next;
      mem_req       <= mem_req_next;
      mem_we        <= mem_we_next;
      mem_addr      <= mem_addr_next;
      mem_be        <= mem_be_next;
      mem_wdata     <= mem_wdata_next;
    end
  end

endmodule
